// File: rtl/lock_pkg.sv
// Shared types and constants for the serial lock front end: FSM state encoding,
// default timing parameters and the code-bit values carried on inp.
package lock_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'd0,
        ST_EMIT         = 2'd1,
        ST_WAIT_RELEASE = 2'd2
    } entry_state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 16;
    localparam int DEF_TIMEOUT_CYCLES  = 1000;

    localparam logic BIT_ZERO = 1'b0;
    localparam logic BIT_ONE  = 1'b1;

endpackage

// File: rtl/button_debouncer.sv
// One pushbutton conditioner: two-flop synchroniser, stability counter that
// toggles the clean level, and a registered rising-edge press strobe.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = lock_pkg::DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             press_q, press_d;

    // The toggle fires on the cycle the count would reach DEBOUNCE_CYCLES,
    // so the counter itself never has to hold that value.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (sync_q[1] == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            level_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b00;
            cnt_q   <= '0;
            level_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], raw};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/code_entry_frontend.sv
// Turns two debounced pushbuttons into one strobed code bit per press.
// Optional idle-abort of a partial entry is built when ENTRY_TIMEOUT_EN is defined.
module code_entry_frontend
    import lock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_zero,
    input  logic btn_one,
    output logic inp,
    output logic inp_valid,
    output logic busy,
    output logic entry_abort
);

    logic level_zero, press_zero;
    logic level_one,  press_one;

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_zero (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_zero),
        .level (level_zero),
        .press (press_zero)
    );

    button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_one (
        .clk   (clk),
        .rst_n (rst_n),
        .raw   (btn_one),
        .level (level_one),
        .press (press_one)
    );

    entry_state_t state_q, state_d;
    logic         inp_q, inp_d;
    logic         valid_q, valid_d;
    logic         busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        inp_d   = inp_q;
        unique case (state_q)
            ST_IDLE: begin
                if (press_zero && press_one) begin
                    state_d = ST_WAIT_RELEASE;
                end else if (press_one) begin
                    state_d = ST_EMIT;
                    inp_d   = BIT_ONE;
                end else if (press_zero) begin
                    state_d = ST_EMIT;
                    inp_d   = BIT_ZERO;
                end
            end
            ST_EMIT: begin
                state_d = ST_WAIT_RELEASE;
            end
            ST_WAIT_RELEASE: begin
                if (!level_zero && !level_one) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Outputs are decoded from the next state so they leave flops directly.
        valid_d = (state_d == ST_EMIT);
        busy_d  = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            inp_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            inp_q   <= inp_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign inp       = inp_q;
    assign inp_valid = valid_q;
    assign busy      = busy_q;

`ifdef ENTRY_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             pending_q, pending_d;
    logic             abort_q, abort_d;

    // Leaving IDLE on an accepted press outranks an abort due in the same cycle.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        pending_d = pending_q;
        abort_d   = 1'b0;
        if ((state_q == ST_IDLE) && (state_d != ST_IDLE)) begin
            tmo_cnt_d = '0;
            if (state_d == ST_EMIT) begin
                pending_d = 1'b1;
            end
        end else if (pending_q && (state_q == ST_IDLE)) begin
            if (tmo_cnt_q == TMO_LAST) begin
                abort_d   = 1'b1;
                pending_d = 1'b0;
                tmo_cnt_d = '0;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
            pending_q <= 1'b0;
            abort_q   <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            pending_q <= pending_d;
            abort_q   <= abort_d;
        end
    end

    assign entry_abort = abort_q;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign entry_abort        = 1'b0;
`endif

endmodule

// File: doc/code_entry_frontend.md
# code_entry_frontend

Upstream input stage for the serial digital lock. It conditions two raw pushbuttons, `btn_zero` and `btn_one`, through synchronisation and debounce, then turns each clean press into one entered code bit. The bit appears on `inp` together with a one-cycle `inp_valid` strobe, and the lock FSM advances only when `inp_valid` is high. Optionally, it aborts a partial entry after a period of inactivity.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive stable synchronised cycles required before the debounced level changes. Legal values are 2 or more.
- `TIMEOUT_CYCLES`, default 1000: idle cycles after the last emitted bit before an abort, used only with `ENTRY_TIMEOUT_EN`.
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `btn_zero` in 1: raw, asynchronous, bouncing button; a press enters bit 0.
- `btn_one` in 1: raw, asynchronous, bouncing button; a press enters bit 1.
- `inp` out 1: value of the most recently entered bit. It holds between strobes. Reset value 0.
- `inp_valid` out 1: one-cycle strobe marking `inp` as a new bit. Reset value 0.
- `busy` out 1: high from press acceptance until both buttons are released and debounced. Reset value 0.
- `entry_abort` out 1: one-cycle pulse telling the lock to return to idle. Reset value 0.

## Operation
- **Synchronisation:** each button passes through a two-flop synchroniser (reset value 0).
- **Debounce:** each synchronised signal drives its own debouncer.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
  - The counter clears whenever the synchronised value equals the debounced level.
  - It increments while the two differ.
  - When it reaches DEBOUNCE_CYCLES, the debounced level toggles and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES therefore never changes the debounced level.
- **Press event:** a registered rising edge of a debounced level.
- **FSM states:** IDLE, EMIT, WAIT_RELEASE.
  - IDLE, press on exactly one button: latch `inp` to that button's value, go to EMIT.
  - IDLE, both buttons pressed in the same cycle: emit nothing, go to WAIT_RELEASE.
  - EMIT: `inp_valid`=1 for exactly this cycle, then go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until both debounced levels are 0, then go to IDLE. Presses during this state are ignored, so holding one button and tapping the other produces no bit.
- `busy` = (state != IDLE).
- Reset asserted in any state: the FSM goes to IDLE, all counters and synchronisers clear, and all outputs go to 0 immediately. A press still in debounce at reset is discarded.
- A button held through reset release is reported as a press after debounce, because the debounced level starts at 0.

## Timing
- Raw edge at cycle 0, stable afterwards: the synchronised value changes at cycle 2.
- The debounced level toggles at cycle 2+DEBOUNCE_CYCLES.
- The FSM enters EMIT at cycle 3+DEBOUNCE_CYCLES, and `inp_valid` is high in that cycle. Latency is exact, with no jitter.
- `inp` is updated in the same cycle `inp_valid` rises and is stable throughout the strobe.
- Minimum spacing between strobes: release debounce plus press debounce, i.e. at least 2·DEBOUNCE_CYCLES+2 cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- Macro `ENTRY_TIMEOUT_EN` defined:
  - An "entry pending" flag sets on each `inp_valid`.
  - An idle counter clears on each `inp_valid` and increments while the flag is set and the state is IDLE.
  - When the counter reaches TIMEOUT_CYCLES, `entry_abort` pulses for one cycle, and the flag and counter clear.
  - A press accepted in the same cycle the limit is reached takes priority: no abort, and the counter clears.
- Macro not defined: the counter and flag are absent, and `entry_abort` is tied to 0.

## Structure
- **Shared package `lock_pkg`:**
  - FSM state enum `entry_state_t`.
  - Default-parameter localparams.
  - Code bit constants `BIT_ZERO`/`BIT_ONE`.
- **Sub-module `button_debouncer`** (synchroniser plus debounce counter plus edge register), instantiated twice.
  - Parameters: DEBOUNCE_CYCLES.
  - Ports: clk, rst_n, raw, level, press.

## Test plan
- **Clean press:** DEBOUNCE_CYCLES=4; `btn_one` raised cleanly at cycle 0 and held 20 cycles → `inp`=1 with `inp_valid` high only at cycle 7; `busy` drops 7 cycles after release.
- **Bounce rejection:** `btn_zero` toggled 1,0,1,0 every 2 cycles, then held low → no strobe. A following 10-cycle clean press → a single strobe with `inp`=0.
- **Sequence 1,0,1:** three clean presses with releases → exactly three strobes carrying `inp` 1, 0, 1, with `inp` holding its value between strobes.
- **Simultaneous and overlapping presses:**
  - Both buttons raised at the same cycle → no strobe, `busy` high until both are released.
  - `btn_one` held while `btn_zero` is tapped → one strobe only, with `inp`=1.
- **Reset mid-operation:** `rst_n` pulled low two cycles before the expected strobe → no strobe, all outputs 0 during reset. A held button → a strobe at DEBOUNCE_CYCLES+3 cycles after reset release.
- **Timeout (`ENTRY_TIMEOUT_EN`, TIMEOUT_CYCLES=50):** one bit entered, then idle → `entry_abort` one-cycle pulse 50 cycles after the idle count starts. No pulse without the macro or with no bit entered.
